// File: rtl/fizzbuzz_pkg.sv
// rtl/fizzbuzz_pkg.sv - shared state/class enums and reset-default divisors for the fizz/buzz sequencer
package fizzbuzz_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fb_state_e;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    FIZZ     = 2'd1,
    BUZZ     = 2'd2,
    FIZZBUZZ = 2'd3
  } fb_class_e;

  localparam int DEF_FIZZ = 3;
  localparam int DEF_BUZZ = 5;

endpackage

// File: rtl/residue_counter.sv
// rtl/residue_counter.sv - incremental modulo counter; reports residue zero without a divider
module residue_counter #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clr,
  input  logic          step,
  input  logic [DW-1:0] divisor,
  output logic          zero
);

  logic [DW-1:0] r_res;
  logic          w_wrap;

  // Divisors 0 and 1 pin the residue at 0; zero is masked separately for divisor 0.
  assign w_wrap = (divisor <= DW'(1)) || (r_res == divisor - DW'(1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_res <= '0;
    end else if (clr) begin
      r_res <= '0;
    end else if (step) begin
      r_res <= w_wrap ? '0 : r_res + DW'(1);
    end
  end

  assign zero = (divisor != '0) && (r_res == '0);

endmodule

// File: rtl/fizzbuzz_sequencer.sv
// rtl/fizzbuzz_sequencer.sv - fizz/buzz run controller; per-class beat stats under FIZZBUZZ_SEQ_STATS_EN
module fizzbuzz_sequencer
  import fizzbuzz_pkg::*;
#(
  parameter  int DW      = 8,
  parameter  int MAX_LEN = 100,
  localparam int CW      = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          cfg_valid,
  input  logic [DW-1:0] cfg_fizz,
  input  logic [DW-1:0] cfg_buzz,
  input  logic [CW-1:0] cfg_len,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_count,
  output logic [1:0]    out_class
`ifdef FIZZBUZZ_SEQ_STATS_EN
  ,
  output logic [CW-1:0] stat_fizz,
  output logic [CW-1:0] stat_buzz,
  output logic [CW-1:0] stat_fizzbuzz
`endif
);

  fb_state_e     r_state;
  fb_state_e     w_state_nxt;
  logic [DW-1:0] r_fizz;
  logic [DW-1:0] r_buzz;
  logic [CW-1:0] r_len;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_len_sat;
  logic [CW-1:0] w_len_eff;
  logic          w_cfg_load;
  logic          w_start;
  logic          w_fire;
  logic          w_last;
  logic          w_fizz_zero;
  logic          w_buzz_zero;

  assign w_cfg_load = (r_state == IDLE) && cfg_valid;
  assign w_start    = (r_state == IDLE) && start;
  assign w_fire     = (r_state == RUN) && out_ready;
  assign w_last     = (r_count + CW'(1)) == r_len;
  assign w_len_sat  = (cfg_len > CW'(MAX_LEN)) ? CW'(MAX_LEN) : cfg_len;
  // A config written alongside start governs the run it starts.
  assign w_len_eff  = w_cfg_load ? w_len_sat : r_len;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (w_len_eff == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (w_fire && w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != IDLE);
    out_valid = (r_state == RUN);
    done      = (r_state == DONE);
    out_class = NONE;
    if (r_state == RUN) begin
      out_class = {w_buzz_zero, w_fizz_zero};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_fizz  <= DW'(DEF_FIZZ);
      r_buzz  <= DW'(DEF_BUZZ);
      r_len   <= CW'(MAX_LEN);
      r_count <= '0;
    end else begin
      if (w_cfg_load) begin
        r_fizz <= cfg_fizz;
        r_buzz <= cfg_buzz;
        r_len  <= w_len_sat;
      end
      if (w_start) begin
        r_count <= '0;
      end else if (w_fire) begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  assign out_count = r_count;

  residue_counter #(.DW(DW)) u_fizz_res (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (w_start),
    .step    (w_fire),
    .divisor (r_fizz),
    .zero    (w_fizz_zero)
  );

  residue_counter #(.DW(DW)) u_buzz_res (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (w_start),
    .step    (w_fire),
    .divisor (r_buzz),
    .zero    (w_buzz_zero)
  );

`ifdef FIZZBUZZ_SEQ_STATS_EN
  logic [CW-1:0] r_stat_fizz;
  logic [CW-1:0] r_stat_buzz;
  logic [CW-1:0] r_stat_fizzbuzz;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_stat_fizz     <= '0;
      r_stat_buzz     <= '0;
      r_stat_fizzbuzz <= '0;
    end else if (w_start) begin
      r_stat_fizz     <= '0;
      r_stat_buzz     <= '0;
      r_stat_fizzbuzz <= '0;
    end else if (w_fire) begin
      case (out_class)
        FIZZ:     r_stat_fizz     <= r_stat_fizz + CW'(1);
        BUZZ:     r_stat_buzz     <= r_stat_buzz + CW'(1);
        FIZZBUZZ: r_stat_fizzbuzz <= r_stat_fizzbuzz + CW'(1);
        default:  ;
      endcase
    end
  end

  assign stat_fizz     = r_stat_fizz;
  assign stat_buzz     = r_stat_buzz;
  assign stat_fizzbuzz = r_stat_fizzbuzz;
`endif

endmodule

// File: tb/tb_fizzbuzz_sequencer.sv
// tb/tb_fizzbuzz_sequencer.sv - self-checking bench for fizzbuzz_sequencer (FIZZBUZZ_SEQ_STATS_EN optional)
module tb_fizzbuzz_sequencer;

  localparam int DW      = 8;
  localparam int MAX_LEN = 100;
  localparam int CW      = $clog2(MAX_LEN + 1);

  logic          clk = 1'b0;
  logic          resetn;
  logic          cfg_valid;
  logic [DW-1:0] cfg_fizz;
  logic [DW-1:0] cfg_buzz;
  logic [CW-1:0] cfg_len;
  logic          start;
  logic          abort;
  logic          busy;
  logic          done;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_count;
  logic [1:0]    out_class;
`ifdef FIZZBUZZ_SEQ_STATS_EN
  logic [CW-1:0] stat_fizz;
  logic [CW-1:0] stat_buzz;
  logic [CW-1:0] stat_fizzbuzz;
`endif

  fizzbuzz_sequencer dut (
    .clk       (clk),
    .resetn    (resetn),
    .cfg_valid (cfg_valid),
    .cfg_fizz  (cfg_fizz),
    .cfg_buzz  (cfg_buzz),
    .cfg_len   (cfg_len),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_class (out_class)
`ifdef FIZZBUZZ_SEQ_STATS_EN
    ,
    .stat_fizz     (stat_fizz),
    .stat_buzz     (stat_buzz),
    .stat_fizzbuzz (stat_fizzbuzz)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int m_f     = 3;
  int m_b     = 5;
  int m_len   = MAX_LEN;

  typedef struct {
    int count;
    int cls;
  } beat_t;

  typedef struct {
    bit load;
    int f;
    int b;
    int len;
    int pct;
    bit noisy;
    int exp_beats;
  } run_t;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_class(input int k, input int f, input int b);
    int c;
    c = 0;
    if (f != 0 && (k % f) == 0) c += 1;
    if (b != 0 && (k % b) == 0) c += 2;
    return c;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // pct < 0 alternates ready 1/0; otherwise ready is high with pct% probability.
  task automatic do_run(input bit load, input int f, input int b, input int len,
                        input int pct, input bit noisy, input string tag, output int beats);
    int k, cyc, budget, sf, sb, sfb, c;
    bit rdy, tog;
    if (load) begin
      m_f = f; m_b = b; m_len = (len > MAX_LEN) ? MAX_LEN : len;
      cfg_valid = 1'b1;
      cfg_fizz  = f[DW-1:0];
      cfg_buzz  = b[DW-1:0];
      cfg_len   = len[CW-1:0];
    end
    start = 1'b1;
    tick;
    cfg_valid = 1'b0;
    start     = 1'b0;
    k = 0; cyc = 0; tog = 1'b1; sf = 0; sb = 0; sfb = 0;
    budget = 20 * m_len + 50;
    while (k < m_len && cyc < budget) begin
      c = ref_class(k, m_f, m_b);
      check({tag, "_valid"}, int'(out_valid), 1);
      check({tag, "_count"}, int'(out_count), k);
      check({tag, "_class"}, int'(out_class), c);
      if (noisy && cyc == 0) begin
        cfg_valid = 1'b1; cfg_fizz = 8'd7; cfg_buzz = 8'd2; cfg_len = 7'd3; start = 1'b1;
      end
      rdy = (pct < 0) ? tog : ($urandom_range(99) < pct);
      tog = ~tog;
      out_ready = rdy;
      tick;
      cfg_valid = 1'b0;
      start     = 1'b0;
      cyc++;
      if (rdy) begin
        if (c == 1) sf++;
        if (c == 2) sb++;
        if (c == 3) sfb++;
        k++;
      end
    end
    out_ready = 1'b0;
    if (k < m_len) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d beats expected %0d", tag, k, m_len);
      abort = 1'b1;
      tick;
      abort = 1'b0;
    end else begin
      check({tag, "_done"}, int'(done), 1);
      check({tag, "_valid_end"}, int'(out_valid), 0);
      if (pct == 100) check({tag, "_latency"}, cyc + 1, m_len + 1);
`ifdef FIZZBUZZ_SEQ_STATS_EN
      check({tag, "_stat_fizz"}, int'(stat_fizz), sf);
      check({tag, "_stat_buzz"}, int'(stat_buzz), sb);
      check({tag, "_stat_fizzbuzz"}, int'(stat_fizzbuzz), sfb);
`endif
      tick;
      check({tag, "_done_pulse"}, int'(done), 0);
      check({tag, "_idle"}, int'(busy), 0);
    end
    beats = k;
  endtask

  beat_t tbl[16];
  run_t  runs[6];

  initial begin
    int beats, f, b, len, pct, expb;
    bit load, noisy;
    int cls_seq[16];

    cls_seq = '{3, 0, 0, 1, 0, 2, 1, 0, 0, 1, 2, 0, 1, 0, 0, 3};
    for (int i = 0; i < 16; i++) tbl[i] = '{i, cls_seq[i]};
    runs[0] = '{1'b1, 3, 5, 16, -1, 1'b0, 16};
    runs[1] = '{1'b1, 3, 5, 0, 100, 1'b0, 0};
    runs[2] = '{1'b1, 0, 1, 4, 100, 1'b1, 4};
    runs[3] = '{1'b0, 0, 0, 0, 100, 1'b0, 4};
    runs[4] = '{1'b1, 3, 5, 120, 100, 1'b0, 100};
    runs[5] = '{1'b1, 1, 0, 7, 60, 1'b0, 7};

    resetn = 1'b0; cfg_valid = 1'b0; cfg_fizz = '0; cfg_buzz = '0; cfg_len = '0;
    start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    repeat (3) tick;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_count", int'(out_count), 0);
    check("rst_class", int'(out_class), 0);
    resetn = 1'b1;
    tick;

    // Reference 3/5/16 run against the literal class table.
    cfg_valid = 1'b1; cfg_fizz = 8'd3; cfg_buzz = 8'd5; cfg_len = 7'd16; start = 1'b1;
    tick;
    cfg_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
    m_f = 3; m_b = 5; m_len = 16;
    for (int i = 0; i < 16; i++) begin
      check("tbl_valid", int'(out_valid), 1);
      check("tbl_count", int'(out_count), tbl[i].count);
      check("tbl_class", int'(out_class), tbl[i].cls);
      check("tbl_nodone", int'(done), 0);
      tick;
    end
    out_ready = 1'b0;
    check("tbl_done_at_17", int'(done), 1);
    tick;
    check("tbl_idle", int'(busy), 0);

    for (int i = 0; i < 6; i++) begin
      do_run(runs[i].load, runs[i].f, runs[i].b, runs[i].len, runs[i].pct,
             runs[i].noisy, $sformatf("run%0d", i), beats);
      check($sformatf("run%0d_beats", i), beats, runs[i].exp_beats);
    end

    // Abort after 5 beats, then restart from stored config and abort on the final handshake.
    cfg_valid = 1'b1; cfg_fizz = 8'd3; cfg_buzz = 8'd5; cfg_len = 7'd16; start = 1'b1;
    m_f = 3; m_b = 5; m_len = 16;
    tick;
    cfg_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
    repeat (5) tick;
    check("abort_pre_count", int'(out_count), 5);
    abort = 1'b1; out_ready = 1'b0;
    tick;
    abort = 1'b0;
    check("abort_valid", int'(out_valid), 0);
    check("abort_busy", int'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      check("abort_nodone", int'(done), 0);
      tick;
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    check("restart_count", int'(out_count), 0);
    check("restart_class", int'(out_class), 3);
    out_ready = 1'b1;
    repeat (15) tick;
    check("final_count", int'(out_count), 15);
    abort = 1'b1;
    tick;
    abort = 1'b0; out_ready = 1'b0;
    check("final_abort_done", int'(done), 0);
    check("final_abort_busy", int'(busy), 0);
`ifdef FIZZBUZZ_SEQ_STATS_EN
    check("final_abort_stat_fizz", int'(stat_fizz), 4);
    check("final_abort_stat_buzz", int'(stat_buzz), 2);
    check("final_abort_stat_fb", int'(stat_fizzbuzz), 2);
`endif
    tick;
    check("final_abort_nodone", int'(done), 0);

    // Reset mid-run restores default config.
    start = 1'b1;
    tick;
    start = 1'b0; out_ready = 1'b1;
    repeat (3) tick;
    resetn = 1'b0;
    tick;
    resetn = 1'b1; out_ready = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_count", int'(out_count), 0);
    check("midrst_class", int'(out_class), 0);
    m_f = 3; m_b = 5; m_len = MAX_LEN;
    do_run(1'b0, 0, 0, 0, 100, 1'b0, "post_rst", beats);
    check("post_rst_beats", beats, MAX_LEN);

`ifdef FIZZBUZZ_SEQ_STATS_EN
    do_run(1'b1, 3, 5, 30, 100, 1'b0, "stats30", beats);
    check("stats30_fizz", int'(stat_fizz), 8);
    check("stats30_buzz", int'(stat_buzz), 4);
    check("stats30_fizzbuzz", int'(stat_fizzbuzz), 2);
`endif

    for (int r = 0; r < 10; r++) begin
      load  = ($urandom_range(3) != 0);
      f     = $urandom_range(7);
      b     = $urandom_range(7);
      len   = $urandom_range(24);
      pct   = $urandom_range(100, 30);
      noisy = $urandom_range(1);
      expb  = load ? ((len > MAX_LEN) ? MAX_LEN : len) : m_len;
      do_run(load, f, b, len, pct, noisy, $sformatf("rnd%0d", r), beats);
      check($sformatf("rnd%0d_beats", r), beats, expb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
